// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter stage after the label lookup table. Selects the
//            next PC each cycle (increment, branch, call/return via a small
//            LIFO return-address stack, stall, halt) and reports run/done.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned PC_W        = 12,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] prog_ctr,
  output logic            running,
  output logic            done,
  output logic            stack_err
);

  localparam int unsigned     IDX_W     = $clog2(STACK_DEPTH);
  localparam int unsigned     SP_W      = IDX_W + 1;
  localparam logic [PC_W-1:0] START_PC  = PC_W'(RESET_PC);
  localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] stack_mem [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc;
  logic [SP_W-1:0] sp_dec;
  logic            stack_empty;
  logic            stack_full;
  logic            do_push;

  // Next-sequential address wraps naturally at 2^PC_W; stack status decode.
  always_comb begin
    pc_inc      = prog_ctr + PC_W'(1);
    sp_dec      = sp - SP_W'(1);
    stack_empty = (sp == '0);
    stack_full  = (sp == SP_FULL);
    // A push happens only when call is the winning control and there is room.
    do_push     = (state == S_RUN) && !stall && !halt && !ret && call && !stack_full;
  end

  // Return-address storage; contents need no reset since the pointer guards them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[sp[IDX_W-1:0]] <= pc_inc;
    end
  end

  // Sequencer state machine: PC, stack pointer, status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prog_ctr  <= START_PC;
      sp        <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          prog_ctr <= START_PC;
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (stall) begin
            // hold everything
          end else if (halt) begin
            // PC stays on the halt instruction
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (ret) begin
            if (!stack_empty) begin
              prog_ctr <= stack_mem[sp_dec[IDX_W-1:0]];
              sp       <= sp_dec;
            end else begin
              stack_err <= 1'b1;
              prog_ctr  <= pc_inc;
            end
          end else if (call) begin
            // On overflow the return address is dropped but the jump still happens.
            if (!stack_full) begin
              sp <= sp + SP_W'(1);
            end else begin
              stack_err <= 1'b1;
            end
            prog_ctr <= target;
          end else if (branch) begin
            prog_ctr <= target;
          end else begin
            prog_ctr <= pc_inc;
          end
        end

        S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            running   <= 1'b1;
            done      <= 1'b0;
            prog_ctr  <= START_PC;
            sp        <= '0;
            stack_err <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer: table of input/expected
//            records driven through a scoreboard queue, plus an async-reset
//            sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            branch = 1'b0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic            halt = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [PC_W-1:0] prog_ctr;
  logic            running;
  logic            done;
  logic            stack_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start, stall, branch, call, ret, halt;
    logic [11:0] target;
    logic [11:0] exp_pc;
    logic        exp_run, exp_done, exp_err;
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    logic        run, dn, err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch(branch),
    .call(call), .ret(ret), .halt(halt), .target(target),
    .prog_ctr(prog_ctr), .running(running), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic s, st, b, c, r, h, input int t,
                     input int pc, input logic rn, dn, er);
    vec_t v;
    v.start = s; v.stall = st; v.branch = b; v.call = c; v.ret = r; v.halt = h;
    v.target = 12'(t); v.exp_pc = 12'(pc);
    v.exp_run = rn; v.exp_done = dn; v.exp_err = er;
    tbl.push_back(v);
  endtask

  // Drive one record before the edge, queue its expectation, compare after it.
  task automatic run_vec(input vec_t v, input int idx);
    exp_t e, g;
    @(negedge clk);
    start = v.start; stall = v.stall; branch = v.branch; call = v.call;
    ret = v.ret; halt = v.halt; target = v.target;
    e.pc = v.exp_pc; e.run = v.exp_run; e.dn = v.exp_done; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: vector %0d got no expectation", idx);
    end else begin
      g = sb.pop_front();
      check($sformatf("v%0d_pc", idx), int'(prog_ctr), int'(g.pc));
      check($sformatf("v%0d_running", idx), int'(running), int'(g.run));
      check($sformatf("v%0d_done", idx), int'(done), int'(g.dn));
      check($sformatf("v%0d_stack_err", idx), int'(stack_err), int'(g.err));
    end
  endtask

  initial begin
    vec_t post[$];
    vec_t v;

    //   st stl br cl rt ht  tgt   pc   run dn er
    add(0, 0, 1, 0, 0, 0, 5,    0,    0, 0, 0);  // IDLE ignores branch
    add(1, 0, 0, 0, 0, 0, 0,    0,    1, 0, 0);  // start: first fetch at 0
    for (int p = 1; p <= 10; p++)
      add(0, 0, 0, 0, 0, 0, 0, p, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 352,  352,  1, 0, 0);  // start ignored in RUN
    add(0, 0, 0, 0, 0, 0, 0,    353,  1, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 1, 0, 0, 0, 7, 353, 1, 0, 0);    // stall beats branch
    add(0, 0, 0, 0, 0, 0, 0,    354,  1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 20,   20,   1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 625,  625,  1, 0, 0);  // push 21
    add(0, 0, 0, 0, 0, 0, 0,    626,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,    627,  1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,    628,  1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,    21,   1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 100,  100,  1, 0, 0);  // call beats branch, push 22
    add(0, 0, 0, 0, 1, 0, 0,    22,   1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 200,  200,  1, 0, 0);  // push 23
    add(0, 0, 0, 1, 0, 0, 300,  300,  1, 0, 0);  // push 201
    add(0, 0, 0, 1, 0, 0, 400,  400,  1, 0, 0);  // push 301
    add(0, 0, 0, 1, 0, 0, 500,  500,  1, 0, 0);  // push 401 (full)
    add(0, 0, 0, 1, 0, 0, 600,  600,  1, 0, 1);  // overflow
    add(0, 0, 0, 0, 1, 0, 0,    401,  1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0,    301,  1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0,    201,  1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0,    23,   1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0,    24,   1, 0, 1);  // underflow: increment
    add(0, 0, 1, 0, 0, 0, 4095, 4095, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,    0,    1, 0, 1);  // wrap
    add(0, 0, 1, 0, 0, 0, 4095, 4095, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 50,   50,   1, 0, 1);  // pushed address wraps to 0
    add(0, 0, 0, 0, 1, 0, 0,    0,    1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 70,   70,   1, 0, 1);  // push 1
    add(0, 1, 0, 0, 0, 1, 0,    70,   1, 0, 1);  // stall beats halt
    add(0, 0, 0, 0, 1, 1, 0,    70,   0, 1, 1);  // halt beats ret
    add(0, 0, 1, 1, 1, 0, 9,    70,   0, 1, 1);  // DONE ignores controls
    add(1, 0, 0, 0, 0, 0, 0,    0,    1, 0, 0);  // restart clears stack/err
    add(0, 0, 0, 0, 1, 0, 0,    1,    1, 0, 1);  // stack was emptied
    add(0, 0, 1, 0, 0, 0, 300,  300,  1, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", int'(prog_ctr), 0);
    check("reset_running", int'(running), 0);
    check("reset_done", int'(done), 0);
    check("reset_stack_err", int'(stack_err), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], i);

    // Asynchronous reset between edges at pc=300
    @(negedge clk);
    start = 0; stall = 0; branch = 0; call = 0; ret = 0; halt = 0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pc", int'(prog_ctr), 0);
    check("async_reset_running", int'(running), 0);
    check("async_reset_stack_err", int'(stack_err), 0);
    @(posedge clk);
    #1;
    check("held_reset_pc", int'(prog_ctr), 0);
    @(negedge clk);
    reset = 1'b0;

    // After reset: start, then ret must underflow (stack pointer cleared)
    v = tbl[0];
    v.start = 1; v.stall = 0; v.branch = 0; v.call = 0; v.ret = 0; v.halt = 0;
    v.target = 0; v.exp_pc = 0; v.exp_run = 1; v.exp_done = 0; v.exp_err = 0;
    post.push_back(v);
    v.start = 0; v.ret = 1; v.exp_pc = 1; v.exp_err = 1;
    post.push_back(v);
    for (int i = 0; i < post.size(); i++)
      run_vec(post[i], 1000 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
